tcdm_mem_bank_emu: RTL and testbench

// - Parametrised multi-bank TCDM memory emulator for interconnect benches and FPGA bring-up.
// - Each bank is single-ported, with configurable read latency and grant back-pressure (none/periodic/LFSR).
// - Keeps saturating per-bank request/grant/stall counters.
// - Sits on the bank side of tcdm_interconnect, in place of an always-granting 1-cycle memory.

---
 rtl/tcdm_mem_bank_emu_pkg.sv | 18 +
 rtl/tcdm_mem_bank_emu_bank.sv | 105 ++++++++++
 rtl/tcdm_mem_bank_emu.sv | 104 ++++++++++
 tb/tb_tcdm_mem_bank_emu.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_mem_bank_emu_pkg.sv
// Shared types and constants for the TCDM memory bank emulator.
package tcdm_mem_bank_emu_pkg;

    typedef enum logic [1:0] {
        STALL_NONE,
        STALL_PERIODIC,
        STALL_LFSR
    } stall_mode_e;

    // Feedback taps 16,14,13,11 of the 16-bit Fibonacci LFSR (bit n-1 for tap n).
    localparam logic [15:0] LfsrTaps     = 16'hB400;
    localparam int unsigned RdLatencyMax = 8;

    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return {state[14:0], ^(state & LfsrTaps)};
    endfunction

endpackage

// File: rtl/tcdm_mem_bank_emu_bank.sv
// One single-ported bank: storage, response pipeline, back-pressure LFSR and
// saturating request/grant/stall counters.
module tcdm_mem_bank_emu_bank
    import tcdm_mem_bank_emu_pkg::*;
#(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned MemAddrBits = 10,
    parameter int unsigned RdLatency   = 1,
    parameter stall_mode_e StallMode   = STALL_NONE,
    parameter int unsigned StallThresh = 4,
    parameter logic [15:0] LfsrSeed    = 16'hACE1,
    parameter int unsigned CntWidth    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [MemAddrBits-1:0] add_i,
    input  logic                   wen_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    input  logic                   ext_stall_i,
    input  logic                   bd_we_i,
    input  logic [MemAddrBits-1:0] bd_addr_i,
    input  logic [DataWidth-1:0]   bd_wdata_i,
    input  logic                   clr_i,
    output logic [CntWidth-1:0]    req_cnt_o,
    output logic [CntWidth-1:0]    gnt_cnt_o,
    output logic [CntWidth-1:0]    stall_cnt_o
);

    localparam int unsigned NumBytes = DataWidth / 8;
    localparam logic [15:0] Seed     = (LfsrSeed == 16'h0) ? 16'h1 : LfsrSeed;

    logic [DataWidth-1:0] mem_q  [2**MemAddrBits];
    logic [RdLatency-1:0] valid_q, valid_d;
    logic [DataWidth-1:0] data_q [RdLatency];
    logic [DataWidth-1:0] data_d [RdLatency];
    logic [15:0]          lfsr_q, lfsr_d;
    logic [CntWidth-1:0]  cnt_q  [3];
    logic [CntWidth-1:0]  cnt_d  [3];
    logic [2:0]           cnt_inc;
    logic                 lfsr_stall, access;

    assign lfsr_stall = (StallMode == STALL_LFSR) && ({1'b0, lfsr_q[3:0]} < 5'(StallThresh));
    // A backdoor write owns the port, so it can never collide with a granted access.
    assign gnt_o      = req_i & ~(ext_stall_i | bd_we_i | lfsr_stall);
    assign access     = req_i & gnt_o;
    assign lfsr_d     = lfsr_step(lfsr_q);
    assign cnt_inc    = {req_i & ~gnt_o, access, req_i};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d    = '0;
        valid_d[0] = access;
        data_d[0]  = (access && !wen_i) ? mem_q[add_i] : '0;
        for (int i = 1; i < RdLatency; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
        for (int k = 0; k < 3; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clr_i) begin
                cnt_d[k] = '0;
            end else if (cnt_inc[k] && (cnt_q[k] != '1)) begin
                cnt_d[k] = cnt_q[k] + CntWidth'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < RdLatency; i++) data_q[i] <= '0;
            lfsr_q  <= Seed;
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the array has no reset so it maps to RAM and keeps its contents across rst_ni.
    always_ff @(posedge clk_i) begin
        if (bd_we_i) begin
            mem_q[bd_addr_i] <= bd_wdata_i;
        end else if (access && wen_i) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (be_i[i]) mem_q[add_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
    end

    assign rvalid_o    = valid_q[RdLatency-1];
    assign rdata_o     = data_q[RdLatency-1];
    assign req_cnt_o   = cnt_q[0];
    assign gnt_cnt_o   = cnt_q[1];
    assign stall_cnt_o = cnt_q[2];

endmodule

// File: rtl/tcdm_mem_bank_emu.sv
// Multi-bank TCDM memory emulator: periodic stall phase, backdoor decode and
// flattening of the per-bank ports.
module tcdm_mem_bank_emu
    import tcdm_mem_bank_emu_pkg::*;
#(
    parameter int unsigned NumBanks    = 16,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned MemAddrBits = 10,
    parameter int unsigned RdLatency   = 1,
    parameter stall_mode_e StallMode   = STALL_NONE,
    parameter int unsigned StallPeriod = 4,
    parameter int unsigned StallThresh = 4,
    parameter logic [15:0] LfsrSeed    = 16'hACE1,
    parameter int unsigned CntWidth    = 32,
    localparam int unsigned BankSelW   = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumBanks-1:0]               req_i,
    output logic [NumBanks-1:0]               gnt_o,
    input  logic [NumBanks*MemAddrBits-1:0]   add_i,
    input  logic [NumBanks-1:0]               wen_i,
    input  logic [NumBanks*DataWidth-1:0]     wdata_i,
    input  logic [NumBanks*DataWidth/8-1:0]   be_i,
    output logic [NumBanks-1:0]               rvalid_o,
    output logic [NumBanks*DataWidth-1:0]     rdata_o,
    input  logic                              bd_we_i,
    input  logic [BankSelW-1:0]               bd_bank_i,
    input  logic [MemAddrBits-1:0]            bd_addr_i,
    input  logic [DataWidth-1:0]              bd_wdata_i,
    input  logic                              clr_i,
    output logic [NumBanks*CntWidth-1:0]      req_cnt_o,
    output logic [NumBanks*CntWidth-1:0]      gnt_cnt_o,
    output logic [NumBanks*CntWidth-1:0]      stall_cnt_o
);

    localparam int unsigned NumBytes = DataWidth / 8;

    if (RdLatency == 0 || RdLatency > RdLatencyMax) begin : g_bad_latency
        $fatal(1, "tcdm_mem_bank_emu: RdLatency must be within 1..8");
    end
    if (DataWidth % 8 != 0) begin : g_bad_width
        $fatal(1, "tcdm_mem_bank_emu: DataWidth must be a multiple of 8");
    end
    if (StallMode == STALL_PERIODIC && StallPeriod < 2) begin : g_bad_period
        $fatal(1, "tcdm_mem_bank_emu: StallPeriod must be >= 2");
    end

    logic [NumBanks-1:0] period_stall;
    logic [NumBanks-1:0] bd_sel;

    // The cycle counter only exists in periodic mode; banks are phase-shifted by index.
    if (StallMode == STALL_PERIODIC && StallPeriod >= 2) begin : g_periodic
        localparam int unsigned CycW = $clog2(StallPeriod);
        logic [CycW-1:0] cyc_q, cyc_d;

        assign cyc_d = (cyc_q == CycW'(StallPeriod - 1)) ? '0 : cyc_q + CycW'(1);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) cyc_q <= '0;
            else         cyc_q <= cyc_d;
        end

        for (genvar b = 0; b < NumBanks; b++) begin : g_phase
            assign period_stall[b] = ((32'(cyc_q) + 32'(b)) % StallPeriod) == 32'd0;
        end
    end else begin : g_no_periodic
        assign period_stall = '0;
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        assign bd_sel[b] = bd_we_i && (32'(bd_bank_i) == 32'(b));

        tcdm_mem_bank_emu_bank #(
            .DataWidth   (DataWidth),
            .MemAddrBits (MemAddrBits),
            .RdLatency   (RdLatency),
            .StallMode   (StallMode),
            .StallThresh (StallThresh),
            .LfsrSeed    (LfsrSeed ^ 16'(b)),
            .CntWidth    (CntWidth)
        ) i_bank (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .req_i       (req_i[b]),
            .gnt_o       (gnt_o[b]),
            .add_i       (add_i[b*MemAddrBits +: MemAddrBits]),
            .wen_i       (wen_i[b]),
            .wdata_i     (wdata_i[b*DataWidth +: DataWidth]),
            .be_i        (be_i[b*NumBytes +: NumBytes]),
            .rvalid_o    (rvalid_o[b]),
            .rdata_o     (rdata_o[b*DataWidth +: DataWidth]),
            .ext_stall_i (period_stall[b]),
            .bd_we_i     (bd_sel[b]),
            .bd_addr_i   (bd_addr_i),
            .bd_wdata_i  (bd_wdata_i),
            .clr_i       (clr_i),
            .req_cnt_o   (req_cnt_o[b*CntWidth +: CntWidth]),
            .gnt_cnt_o   (gnt_cnt_o[b*CntWidth +: CntWidth]),
            .stall_cnt_o (stall_cnt_o[b*CntWidth +: CntWidth])
        );
    end

endmodule

// File: tb/tb_tcdm_mem_bank_emu.sv
// Bench for tcdm_mem_bank_emu: three instances (no stall / periodic / LFSR) share
// one stimulus stream and are compared against a transaction-level model.
module tb_tcdm_mem_bank_emu;
    import tcdm_mem_bank_emu_pkg::*;

    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 4;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic [NB-1:0]    req_i, wen_i;
    logic [NB*AW-1:0] add_i;
    logic [NB*DW-1:0] wdata_i;
    logic [NB*4-1:0]  be_i;
    logic             bd_we_i, clr_i;
    logic [1:0]       bd_bank_i;
    logic [AW-1:0]    bd_addr_i;
    logic [DW-1:0]    bd_wdata_i;

    logic [NB-1:0]    gnt    [3];
    logic [NB-1:0]    rvalid [3];
    logic [NB*DW-1:0] rdata  [3];
    logic [NB*4-1:0]  cnt_a  [3];
    logic [NB*8-1:0]  cnt_b  [3];
    logic [NB*8-1:0]  cnt_c  [3];

    tcdm_mem_bank_emu #(.NumBanks(NB), .DataWidth(DW), .MemAddrBits(AW), .RdLatency(3),
        .StallMode(STALL_NONE), .CntWidth(4)) dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt[0]), .add_i(add_i),
        .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
        .bd_we_i(bd_we_i), .bd_bank_i(bd_bank_i), .bd_addr_i(bd_addr_i), .bd_wdata_i(bd_wdata_i),
        .clr_i(clr_i), .req_cnt_o(cnt_a[0]), .gnt_cnt_o(cnt_a[1]), .stall_cnt_o(cnt_a[2]));

    tcdm_mem_bank_emu #(.NumBanks(NB), .DataWidth(DW), .MemAddrBits(AW), .RdLatency(1),
        .StallMode(STALL_PERIODIC), .StallPeriod(4), .CntWidth(8)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt[1]), .add_i(add_i),
        .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
        .bd_we_i(bd_we_i), .bd_bank_i(bd_bank_i), .bd_addr_i(bd_addr_i), .bd_wdata_i(bd_wdata_i),
        .clr_i(clr_i), .req_cnt_o(cnt_b[0]), .gnt_cnt_o(cnt_b[1]), .stall_cnt_o(cnt_b[2]));

    tcdm_mem_bank_emu #(.NumBanks(NB), .DataWidth(DW), .MemAddrBits(AW), .RdLatency(2),
        .StallMode(STALL_LFSR), .StallThresh(8), .CntWidth(8)) dut_c (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt[2]), .add_i(add_i),
        .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]),
        .bd_we_i(bd_we_i), .bd_bank_i(bd_bank_i), .bd_addr_i(bd_addr_i), .bd_wdata_i(bd_wdata_i),
        .clr_i(clr_i), .req_cnt_o(cnt_c[0]), .gnt_cnt_o(cnt_c[1]), .stall_cnt_o(cnt_c[2]));

    // Reference model state
    int          errors, checks, ecount, since_rst;
    int          lat  [3] = '{3, 1, 2};
    int unsigned cmax [3] = '{15, 255, 255};
    logic [DW-1:0] mem_m  [3][NB][16];
    int unsigned   cnt_m  [3][NB][3];
    int            due_m  [3*NB][$];
    logic [DW-1:0] dat_m  [3*NB][$];
    logic [15:0]   lfsr_m [NB];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cnt_obs(input int d, input int b, input int k);
        case (d)
            0:       return 8'(cnt_a[k][b*4 +: 4]);
            1:       return cnt_b[k][b*8 +: 8];
            default: return cnt_c[k][b*8 +: 8];
        endcase
    endfunction

    task automatic idle();
        req_i = '0; wen_i = '0; add_i = '0; wdata_i = '0; be_i = '0;
        bd_we_i = 1'b0; bd_bank_i = '0; bd_addr_i = '0; bd_wdata_i = '0; clr_i = 1'b0;
    endtask

    task automatic drive(input int b, input logic req, input logic wen, input logic [AW-1:0] a,
                         input logic [DW-1:0] data, input logic [3:0] be);
        req_i[b] = req; wen_i[b] = wen; add_i[b*AW +: AW] = a;
        wdata_i[b*DW +: DW] = data; be_i[b*4 +: 4] = be;
    endtask

    task automatic backdoor(input int b, input logic [AW-1:0] a, input logic [DW-1:0] data);
        bd_we_i = 1'b1; bd_bank_i = 2'(b); bd_addr_i = a; bd_wdata_i = data;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3*NB; i++) begin
            due_m[i].delete();
            dat_m[i].delete();
        end
        for (int d = 0; d < 3; d++)
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < 3; k++) cnt_m[d][b][k] = 0;
        for (int b = 0; b < NB; b++) begin
            lfsr_m[b] = 16'hACE1 ^ 16'(b);
            if (lfsr_m[b] == 16'h0) lfsr_m[b] = 16'h1;
        end
        since_rst = 0;
    endtask

    task automatic bump(input int d, input int b, input int k, input logic inc);
        if (clr_i) cnt_m[d][b][k] = 0;
        else if (inc && cnt_m[d][b][k] < cmax[d]) cnt_m[d][b][k]++;
    endtask

    // Called at a negedge with inputs already driven: checks grants, applies the
    // edge to the model, then checks responses at the following negedge.
    task automatic tick();
        logic [NB-1:0]    g_exp, v_exp;
        logic [NB*DW-1:0] d_exp;
        logic [AW-1:0]    a;
        logic             stall;
        int               idx;
        #1;
        for (int d = 0; d < 3; d++) begin
            for (int b = 0; b < NB; b++) begin
                stall = bd_we_i && (int'(bd_bank_i) == b);
                if (d == 1) stall = stall || (((since_rst + b) % 4) == 0);
                if (d == 2) stall = stall || (lfsr_m[b][3:0] < 4'd8);
                g_exp[b] = req_i[b] && !stall;
            end
            chk($sformatf("gnt_dut%0d", d), gnt[d], g_exp);
            for (int b = 0; b < NB; b++) begin
                idx = d*NB + b;
                a   = add_i[b*AW +: AW];
                if (g_exp[b]) begin
                    due_m[idx].push_back(ecount + lat[d]);
                    if (wen_i[b]) begin
                        dat_m[idx].push_back('0);
                        for (int i = 0; i < 4; i++)
                            if (be_i[b*4+i]) mem_m[d][b][a][i*8 +: 8] = wdata_i[b*DW+i*8 +: 8];
                    end else begin
                        dat_m[idx].push_back(mem_m[d][b][a]);
                    end
                end
                bump(d, b, 0, req_i[b]);
                bump(d, b, 1, g_exp[b]);
                bump(d, b, 2, req_i[b] && !g_exp[b]);
            end
            if (bd_we_i) mem_m[d][bd_bank_i][bd_addr_i] = bd_wdata_i;
        end
        for (int b = 0; b < NB; b++)
            lfsr_m[b] = {lfsr_m[b][14:0], lfsr_m[b][15] ^ lfsr_m[b][13] ^ lfsr_m[b][12] ^ lfsr_m[b][10]};
        since_rst++;
        ecount++;
        @(posedge clk_i);
        @(negedge clk_i);
        for (int d = 0; d < 3; d++) begin
            v_exp = '0;
            d_exp = '0;
            for (int b = 0; b < NB; b++) begin
                idx = d*NB + b;
                if (due_m[idx].size() > 0 && due_m[idx][0] == ecount) begin
                    v_exp[b] = 1'b1;
                    d_exp[b*DW +: DW] = dat_m[idx][0];
                    void'(due_m[idx].pop_front());
                    void'(dat_m[idx].pop_front());
                end
            end
            chk($sformatf("rvalid_dut%0d", d), rvalid[d], v_exp);
            chk($sformatf("rdata_dut%0d", d), rdata[d], d_exp);
        end
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_rvalid_dut%0d", d), rvalid[d], '0);
            chk($sformatf("rst_rdata_dut%0d", d), rdata[d], '0);
            chk($sformatf("rst_gnt_dut%0d", d), gnt[d], '0);
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < 3; k++) chk($sformatf("rst_cnt%0d_%0d_%0d", d, b, k), cnt_obs(d, b, k), 0);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    initial begin
        errors = 0; checks = 0; ecount = 0;
        idle();
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i);
        do_reset();

        // Preload every word so later reads have defined data.
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 16; a++) begin
                idle();
                backdoor(b, 4'(a), $urandom());
                tick();
            end
        do_reset();

        // Periodic stall on bank 0 for 100 cycles; also saturates the 4-bit counters.
        idle();
        drive(0, 1'b1, 1'b0, 4'd0, '0, 4'h0);
        for (int n = 0; n < 100; n++) tick();
        chk("per_req_cnt", cnt_obs(1, 0, 0), 8'd100);
        chk("per_gnt_cnt", cnt_obs(1, 0, 1), 8'd75);
        chk("per_stall_cnt", cnt_obs(1, 0, 2), 8'd25);
        chk("sat_req_cnt", cnt_obs(0, 0, 0), 8'h0F);

        clr_i = 1'b1;
        tick();
        chk("clr_zero", cnt_obs(0, 0, 0), 8'd0);
        clr_i = 1'b0;
        tick();
        chk("clr_then_one", cnt_obs(0, 0, 0), 8'd1);

        // Write then read bank 2 address 5.
        idle();
        drive(2, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 4'hF);
        #1 chk("wr_gnt", gnt[0][2], 1'b1);
        tick();
        idle();
        drive(2, 1'b1, 1'b0, 4'd5, '0, 4'h0);
        tick();
        chk("wr_rvalid_early", rvalid[0][2], 1'b0);
        idle();
        tick();
        chk("wr_rvalid", rvalid[0][2], 1'b1);
        chk("wr_rdata_zero", rdata[0][2*DW +: DW], 32'h0);
        tick();
        chk("rd_rvalid", rvalid[0][2], 1'b1);
        chk("rd_rdata", rdata[0][2*DW +: DW], 32'hDEADBEEF);
        tick();
        chk("rd_rvalid_end", rvalid[0][2], 1'b0);

        // Byte-enable merge over backdoor-preloaded data.
        idle();
        backdoor(1, 4'd3, 32'h11223344);
        tick();
        idle();
        drive(1, 1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'b0101);
        tick();
        idle();
        drive(1, 1'b1, 1'b0, 4'd3, '0, 4'h0);
        tick();
        idle();
        tick();
        tick();
        chk("be_rvalid", rvalid[0][1], 1'b1);
        chk("be_rdata", rdata[0][DW +: DW], 32'h11BB33DD);

        // Backdoor conflicts with a request on the same bank.
        idle();
        drive(1, 1'b1, 1'b0, 4'd0, '0, 4'h0);
        backdoor(1, 4'd7, 32'h5A5AC3C3);
        #1 chk("bd_gnt_blocked", gnt[0][1], 1'b0);
        tick();
        chk("bd_stall_cnt", cnt_obs(0, 1, 2), 8'd1);
        idle();
        drive(1, 1'b1, 1'b0, 4'd7, '0, 4'h0);
        tick();
        idle();
        tick();
        tick();
        chk("bd_data_landed", rdata[0][DW +: DW], 32'h5A5AC3C3);

        // Reset while a read is in flight.
        idle();
        drive(3, 1'b1, 1'b0, 4'd2, '0, 4'h0);
        tick();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("rst_drop", rvalid[0][3], 1'b0);
        end
        drive(3, 1'b1, 1'b0, 4'd2, '0, 4'h0);
        tick();
        idle();
        tick();
        tick();
        chk("rst_keep_rvalid", rvalid[0][3], 1'b1);
        chk("rst_keep_data", rdata[0][3*DW +: DW], mem_m[0][3][2]);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int b = 0; b < NB; b++)
                drive(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      $urandom(), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 7) == 0) backdoor(int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom());
            clr_i = ($urandom_range(0, 31) == 0);
            tick();
        end
        idle();
        repeat (4) tick();
        for (int d = 0; d < 3; d++)
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < 3; k++)
                    chk($sformatf("end_cnt%0d_%0d_%0d", d, b, k), cnt_obs(d, b, k), 8'(cnt_m[d][b][k]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
